// File: rtl/sdspi_perf_meter.sv
// rtl/sdspi_perf_meter.sv - cycle, SCLK-edge and CS-low counters with watchdog for one SD-SPI benchmark run
module sdspi_perf_meter #(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic                 sclk_in,
  input  logic                 cs_in,
  input  logic [1:0]           sel,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] sclk_count,
  output logic [CNT_WIDTH-1:0] cs_low_cycles,
  output logic [CNT_WIDTH-1:0] dout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX       = '1;
  localparam logic [CNT_WIDTH:0]   TIMEOUT_LIMIT = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

  logic [1:0] state;
  logic       start_q;
  logic       sclk_q;
  logic       start_edge;
  logic       sclk_edge;
  logic       at_limit;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign start_edge = start & ~start_q;
  assign sclk_edge  = sclk_in & ~sclk_q;
  // Widened compare so a limit of 2^CNT_WIDTH-1 cannot overflow the sum.
  assign at_limit   = ({1'b0, cycle_count} + (CNT_WIDTH+1)'(1)) == TIMEOUT_LIMIT;

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign timeout = (state == S_TIMEOUT);

  // Edge-detect history, run state machine and the three counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      start_q       <= 1'b0;
      sclk_q        <= 1'b0;
      cycle_count   <= '0;
      sclk_count    <= '0;
      cs_low_cycles <= '0;
    end else begin
      start_q <= start;
      sclk_q  <= sclk_in;
      case (state)
        S_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (sclk_edge) sclk_count <= sat_inc(sclk_count);
          if (!cs_in)    cs_low_cycles <= sat_inc(cs_low_cycles);
          if (finish)        state <= S_DONE;
          else if (at_limit) state <= S_TIMEOUT;
        end
        default: begin
          if (start_edge) begin
            cycle_count   <= '0;
            sclk_count    <= '0;
            cs_low_cycles <= '0;
            state         <= S_RUN;
          end
        end
      endcase
    end
  end

  // Registered display word selected by sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      case (sel)
        2'd0:    dout <= cycle_count;
        2'd1:    dout <= sclk_count;
        2'd2:    dout <= cs_low_cycles;
        default: dout <= {{(CNT_WIDTH-3){1'b0}}, timeout, done, busy};
      endcase
    end
  end

endmodule

// File: doc/sdspi_perf_meter.md
Name: sdspi_perf_meter

Overview:
Measurement stage directly downstream of the SD-SPI unit under test.
- Watches the autotest start pulse, the UUT finish flag and the muxed SPI bus (sclk, cs).
- Produces the elapsed-cycle, SCLK-edge and CS-active counts for one benchmark run.
- Holds the results and drives a selectable 32-bit word to the debug/display path.
- Adds a watchdog so a hung UUT run is flagged instead of blocking the autotest sequence.

Parameters:
CNT_WIDTH, 32, width of every counter and of dout
TIMEOUT_CYCLES, 200000000, clk cycles in RUN before watchdog fires (2 s at 100 MHz); must be ≥2 and ≤2^CNT_WIDTH-1

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  UUT start from autotest; a measurement begins on its rising edge
finish  in  1  UUT finish flag (level)
sclk_in  in  1  SPI clock after the UUT mux; synchronous to clk
cs_in  in  1  SPI chip select after the UUT mux; active low
sel  in  2  dout select
busy  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  high in TIMEOUT
cycle_count  out  CNT_WIDTH  clk cycles of the last run
sclk_count  out  CNT_WIDTH  sclk_in rising edges in the last run
cs_low_cycles  out  CNT_WIDTH  RUN cycles with cs_in=0
dout  out  CNT_WIDTH  registered selected word for the display

Behaviour:
- Reset (rst=1 at a clk edge) forces IDLE and clears all registers, including start_q and sclk_q. Every output is 0 the next cycle. This applies equally mid-RUN.
- start_q and sclk_q are 1-cycle delayed copies of start and sclk_in.
- start_edge = start & ~start_q.
- sclk_edge = sclk_in & ~sclk_q.
- States: IDLE, RUN, DONE, TIMEOUT. Outputs busy, done and timeout decode these states directly.
- IDLE/DONE/TIMEOUT with start_edge (cycle T0):
  - clear all three counters;
  - go to RUN.
  - Otherwise hold state and counters; results stay stable indefinitely.
- RUN, every cycle:
  - cycle_count += 1;
  - sclk_count += 1 if sclk_edge;
  - cs_low_cycles += 1 if cs_in=0.
- RUN exit:
  - finish=1 → DONE, with this cycle's increments applied. If finish is first seen at T0+N (N≥1), cycle_count = N.
  - else if cycle_count+1 == TIMEOUT_CYCLES → TIMEOUT, with increments applied, so cycle_count = TIMEOUT_CYCLES.
  - finish has priority over timeout in the same cycle.
- finish is ignored at T0 itself; the first sample is at T0+1. finish held high from a previous run therefore ends the new run at N=1.
- start_edge during RUN is ignored. start held high does not retrigger.
- All counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- sclk_q is updated in every state. An sclk_in rising edge at T0+1 that was already high at T0 is not counted.
- dout is registered, with 1-cycle latency from sel or counter change:
  - sel=0: cycle_count
  - sel=1: sclk_count
  - sel=2: cs_low_cycles
  - sel=3: {zeros, timeout, done, busy}, with busy at bit 0.

Test Plan:
- Basic run: rst, start pulse at T0, finish=1 at T0+100, sclk_in static, cs_in=1.
  → done=1 from T0+101; cycle_count=100, sclk_count=0, cs_low_cycles=0; busy=0.
- SCLK/CS counting: after start, sclk_in toggles every 2 clk (period 4), cs_in=0 for cycles T0+10..T0+49, finish at T0+80.
  → sclk_count=20, cs_low_cycles=40, cycle_count=80.
- Watchdog: TIMEOUT_CYCLES=50, finish never asserted.
  → timeout=1 from T0+51, cycle_count=50, done=0.
  - Then assert finish: stays in TIMEOUT.
  - Then a new start_edge: busy=1, counters cleared.
- Priority: TIMEOUT_CYCLES=50, finish first asserted at T0+50.
  → done=1, timeout=0, cycle_count=50.
- Reset mid-run: start, then rst at T0+30 for one cycle.
  → all outputs 0 next cycle, state IDLE.
  - finish afterwards has no effect.
- Retrigger and dout: start held high through the run, a second start pulse mid-RUN, finish at T0+20.
  → cycle_count=20; no restart.
  - sel=3 gives dout=0x00000002 one cycle after sel changes.
  - sel=0 gives dout=20.
